ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Sits directly downstream of the PS/2 receiver FIFO and drains scan-code set 2 bytes from it through the receiver's ready/nextdata_n handshake.
- Folds the E0 (extended) and F0 (break) prefixes into single key events, tracks shift and held-key state, and suppresses typematic repeats in the press counter.
- Produces ASCII for the display/console stages.

Parameters:
- COUNT_W, 8: width of the press counter; wraps modulo 2^COUNT_W.
- COUNT_MODIFIERS, 0: when 1, shift makes also increment the counter.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_clr_n  in  1  asynchronous active-low reset.
- i_data  in  8  FIFO head byte from the receiver.
- i_ready  in  1  receiver has at least one byte.
- o_nextdata_n  out  1  registered; low for exactly one cycle pops the FIFO head.
- o_key_valid  out  1  one-cycle pulse marking a decoded key event.
- o_key_code  out  8  final scan byte of the event (prefixes stripped).
- o_key_ext  out  1  event was E0-prefixed.
- o_key_break  out  1  event is a release.
- o_key_repeat  out  1  make of the key already held (typematic).
- o_ascii  out  8  ASCII of the event; 0x00 if unmapped, extended or break.
- o_shift  out  1  left (0x12) or right (0x59) shift currently held.
- o_key_down  out  1  a non-modifier key is held.
- o_press_count  out  COUNT_W  number of counted key presses.

Behaviour:
- Reset (asynchronous, i_clr_n=0):
  - Outputs: o_nextdata_n=1; every other output 0.
  - Internal state: FSM=IDLE; pending ext/brk flags, both shift flags and the held-key register (code+ext+valid) cleared.
  - Asserting reset mid-byte abandons that byte; nothing is emitted.
- FSM, 3 cycles per byte:
  - IDLE: if i_ready=1, latch i_data into byte_r, set o_nextdata_n<=0, go POP. Otherwise stay.
  - POP: o_nextdata_n is low this cycle. Set o_nextdata_n<=1, go DECODE. The receiver advances its read pointer at this edge, so i_ready/i_data are valid again in DECODE.
  - DECODE: process byte_r as below, go IDLE. i_ready is ignored in POP and DECODE.
- Byte processing in DECODE:
  - 0xE0: set ext_pend. No event.
  - 0xF0: set brk_pend. No event.
  - 0x00 or 0xFF (keyboard error codes): clear both pending flags. No event.
  - Any other byte: emit an event next cycle and clear both pending flags.
    - o_key_valid=1, o_key_code=byte_r, o_key_ext=ext_pend, o_key_break=brk_pend.
    - o_key_* hold their values until the next event; only o_key_valid pulses.
- Shift handling (non-extended 0x12/0x59): make sets and break clears that side's flag; o_shift is the OR of both. Shift events never touch the held-key register.
- Non-modifier make:
  - If the held key is valid with the same code and ext: o_key_repeat=1, no count.
  - Else: held key <= this key, o_key_repeat=0, o_press_count += 1.
- Non-modifier break: if it matches the held key, invalidate it; otherwise held-key state is unchanged. o_key_repeat=0.
- Shift make increments the counter only when COUNT_MODIFIERS=1, and only on its first make; repeats of a held shift never count.
- o_key_down = held-key valid.
- o_press_count wraps from all-ones to 0 with no flag.
- o_ascii: combinational lookup of byte_r, registered with the event.
  - Covers non-extended letters (A-Z; uppercase iff o_shift), digits 0-9 and space 0x29.
  - Reflects the shift state before the current event is applied.
  - 0x00 for break, extended or unmapped codes.
- Back-to-back bytes (FIFO holding several): sustained throughput of one byte per 3 cycles, with no bubbles beyond that.

Decomposition:
- Shared package ps2_pkg holds:
  - Prefix and error constants: PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_ERR0=8'h00, PS2_ERR1=8'hFF.
  - PS2_LSHIFT=8'h12, PS2_RSHIFT=8'h59.
  - FSM state encoding: IDLE/POP/DECODE.
- One sub-module: ps2_scancode_to_ascii. Purely combinational; inputs code and shift; output ascii.

Test Plan:
- Reset then feed 0x1C, F0 1C: first event code 1C, break=0, ascii 0x61 ('a'), count 1, key_down=1. Second event break=1, ascii 0, count 1, key_down=0.
- Feed 12, 1C, F0 1C, F0 12: shift=1 after the first byte; 'A' event ascii 0x41; shift=0 at the end; count 1 (COUNT_MODIFIERS=0); with COUNT_MODIFIERS=1, count 2.
- Feed E0 75, E0 F0 75: two events, code 75, ext=1, break 0 then 1; ascii 0 for both; count 1.
- Feed 1C 1C 1C F0 1C: repeat flags 0,1,1 then 0 on the break; count 1.
- Preload the FIFO with 8 bytes: o_nextdata_n low one cycle every 3 cycles; all bytes consumed in order; no byte popped twice or skipped.
- Count 255 presses, then one more make: count reads 0. Pulse i_clr_n low during POP: all outputs return to reset values immediately, and no event is emitted afterwards for the abandoned byte.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code set 2 decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DECODE
  } ps2_state_t;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational set 2 scan-code to ASCII map: letters (case follows shift),
// digits and space; anything else yields 0x00.
module ps2_scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] letter;

  always_comb begin
    letter = 8'h00;
    case (code)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: letter = 8'h00;
    endcase
  end

  always_comb begin
    ascii = 8'h00;
    if (letter != 8'h00) begin
      ascii = shift ? (letter - 8'h20) : letter;
    end else begin
      case (code)
        8'h45: ascii = "0";
        8'h16: ascii = "1";
        8'h1E: ascii = "2";
        8'h26: ascii = "3";
        8'h25: ascii = "4";
        8'h2E: ascii = "5";
        8'h36: ascii = "6";
        8'h3D: ascii = "7";
        8'h3E: ascii = "8";
        8'h46: ascii = "9";
        8'h29: ascii = " ";
        default: ascii = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Drains scan-code set 2 bytes from the PS/2 receiver FIFO, folds E0/F0
// prefixes into key events, tracks shift/held-key state and counts presses.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int COUNT_W         = 8,
  parameter bit COUNT_MODIFIERS = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_clr_n,
  input  logic [7:0]         i_data,
  input  logic               i_ready,
  output logic               o_nextdata_n,
  output logic               o_key_valid,
  output logic [7:0]         o_key_code,
  output logic               o_key_ext,
  output logic               o_key_break,
  output logic               o_key_repeat,
  output logic [7:0]         o_ascii,
  output logic               o_shift,
  output logic               o_key_down,
  output logic [COUNT_W-1:0] o_press_count
);

  ps2_state_t         state_reg, state_next;
  logic [7:0]         byte_reg, byte_next;
  logic               nextdata_n_reg, nextdata_n_next;
  logic               ext_pend_reg, ext_pend_next;
  logic               brk_pend_reg, brk_pend_next;
  logic               lshift_reg, lshift_next;
  logic               rshift_reg, rshift_next;
  logic [7:0]         held_code_reg, held_code_next;
  logic               held_ext_reg, held_ext_next;
  logic               held_valid_reg, held_valid_next;
  logic               key_valid_reg, key_valid_next;
  logic [7:0]         key_code_reg, key_code_next;
  logic               key_ext_reg, key_ext_next;
  logic               key_break_reg, key_break_next;
  logic               key_repeat_reg, key_repeat_next;
  logic [7:0]         ascii_reg, ascii_next;
  logic [COUNT_W-1:0] count_reg, count_next;

  logic       shift_cur;
  logic [7:0] lut_ascii;
  logic       is_lshift, is_rshift, is_error, held_hit, shift_was;

  // Shift state before the current event drives the case of the letter.
  assign shift_cur = lshift_reg | rshift_reg;

  ps2_scancode_to_ascii u_ascii (
    .code  (byte_reg),
    .shift (shift_cur),
    .ascii (lut_ascii)
  );

  assign is_lshift = !ext_pend_reg && (byte_reg == PS2_LSHIFT);
  assign is_rshift = !ext_pend_reg && (byte_reg == PS2_RSHIFT);
  assign is_error  = (byte_reg == PS2_ERR0) || (byte_reg == PS2_ERR1);
  assign held_hit  = held_valid_reg && (held_code_reg == byte_reg) &&
                     (held_ext_reg == ext_pend_reg);
  assign shift_was = is_lshift ? lshift_reg : rshift_reg;

  always_comb begin
    state_next      = state_reg;
    byte_next       = byte_reg;
    nextdata_n_next = nextdata_n_reg;
    ext_pend_next   = ext_pend_reg;
    brk_pend_next   = brk_pend_reg;
    lshift_next     = lshift_reg;
    rshift_next     = rshift_reg;
    held_code_next  = held_code_reg;
    held_ext_next   = held_ext_reg;
    held_valid_next = held_valid_reg;
    key_valid_next  = 1'b0;
    key_code_next   = key_code_reg;
    key_ext_next    = key_ext_reg;
    key_break_next  = key_break_reg;
    key_repeat_next = key_repeat_reg;
    ascii_next      = ascii_reg;
    count_next      = count_reg;

    case (state_reg)
      IDLE: begin
        if (i_ready) begin
          byte_next       = i_data;
          nextdata_n_next = 1'b0;
          state_next      = POP;
        end
      end
      POP: begin
        nextdata_n_next = 1'b1;
        state_next      = DECODE;
      end
      DECODE: begin
        state_next = IDLE;
        if (byte_reg == PS2_EXT) begin
          ext_pend_next = 1'b1;
        end else if (byte_reg == PS2_BRK) begin
          brk_pend_next = 1'b1;
        end else begin
          ext_pend_next = 1'b0;
          brk_pend_next = 1'b0;
          if (!is_error) begin
            key_valid_next  = 1'b1;
            key_code_next   = byte_reg;
            key_ext_next    = ext_pend_reg;
            key_break_next  = brk_pend_reg;
            key_repeat_next = 1'b0;
            ascii_next      = (ext_pend_reg || brk_pend_reg) ? 8'h00 : lut_ascii;
            if (is_lshift || is_rshift) begin
              // Modifiers keep their own flags and never disturb the held key.
              if (!brk_pend_reg) begin
                key_repeat_next = shift_was;
                if (COUNT_MODIFIERS && !shift_was) begin
                  count_next = count_reg + COUNT_W'(1);
                end
              end
              if (is_lshift) lshift_next = !brk_pend_reg;
              else           rshift_next = !brk_pend_reg;
            end else if (!brk_pend_reg) begin
              if (held_hit) begin
                key_repeat_next = 1'b1;
              end else begin
                held_code_next  = byte_reg;
                held_ext_next   = ext_pend_reg;
                held_valid_next = 1'b1;
                count_next      = count_reg + COUNT_W'(1);
              end
            end else if (held_hit) begin
              held_valid_next = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      state_reg      <= IDLE;
      byte_reg       <= 8'h00;
      nextdata_n_reg <= 1'b1;
      ext_pend_reg   <= 1'b0;
      brk_pend_reg   <= 1'b0;
      lshift_reg     <= 1'b0;
      rshift_reg     <= 1'b0;
      held_code_reg  <= 8'h00;
      held_ext_reg   <= 1'b0;
      held_valid_reg <= 1'b0;
      key_valid_reg  <= 1'b0;
      key_code_reg   <= 8'h00;
      key_ext_reg    <= 1'b0;
      key_break_reg  <= 1'b0;
      key_repeat_reg <= 1'b0;
      ascii_reg      <= 8'h00;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      byte_reg       <= byte_next;
      nextdata_n_reg <= nextdata_n_next;
      ext_pend_reg   <= ext_pend_next;
      brk_pend_reg   <= brk_pend_next;
      lshift_reg     <= lshift_next;
      rshift_reg     <= rshift_next;
      held_code_reg  <= held_code_next;
      held_ext_reg   <= held_ext_next;
      held_valid_reg <= held_valid_next;
      key_valid_reg  <= key_valid_next;
      key_code_reg   <= key_code_next;
      key_ext_reg    <= key_ext_next;
      key_break_reg  <= key_break_next;
      key_repeat_reg <= key_repeat_next;
      ascii_reg      <= ascii_next;
      count_reg      <= count_next;
    end
  end

  assign o_nextdata_n  = nextdata_n_reg;
  assign o_key_valid   = key_valid_reg;
  assign o_key_code    = key_code_reg;
  assign o_key_ext     = key_ext_reg;
  assign o_key_break   = key_break_reg;
  assign o_key_repeat  = key_repeat_reg;
  assign o_ascii       = ascii_reg;
  assign o_shift       = shift_cur;
  assign o_key_down    = held_valid_reg;
  assign o_press_count = count_reg;

endmodule
